rll_key_loader: RTL and testbench

//  Serial key-delivery stage that sits directly upstream of the RLL-locked

---
 rtl/rll_key_loader.sv | 111 +++++++++++
 tb/tb_rll_key_loader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rll_key_loader.sv
// Serial key loader: shifts a parity-protected key in LSB first, verifies
// it, and commits it atomically to the register driving the locked core.
module rll_key_loader #(
  parameter int KEY_W        = 16,
  parameter bit ALLOW_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic             sdata,
  input  logic             svalid,
  output logic             sready,
  output logic [KEY_W-1:0] key_o,
  output logic             key_valid,
  output logic             load_err,
  output logic             busy
);

  localparam int CW = $clog2(KEY_W + 1);
  localparam int IW = (KEY_W > 1) ? $clog2(KEY_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(KEY_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_CHECK,
    S_LOCKED,
    S_ERR
  } state_e;

  state_e           state_q;
  logic [KEY_W-1:0] shadow_q;
  logic [KEY_W-1:0] key_q;
  logic [CW-1:0]    cnt_q;
  logic             par_q;
  logic             sready_q;
  logic             busy_q;
  logic             kv_q;
  logic             err_q;

  logic beat;
  logic ok;
  logic go;

  assign beat = svalid & sready_q;
  assign ok   = ~(^shadow_q ^ par_q);
  assign go   = load_start & ((state_q == S_IDLE) |
                              (state_q == S_ERR) |
                              ((state_q == S_LOCKED) & ALLOW_RELOAD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      key_q    <= '0;
      cnt_q    <= '0;
      par_q    <= 1'b0;
      sready_q <= 1'b0;
      busy_q   <= 1'b0;
      kv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else if (go) begin
      state_q  <= S_SHIFT;
      shadow_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      sready_q <= 1'b1;
      busy_q   <= 1'b1;
    end else begin
      unique case (state_q)
        S_SHIFT: begin
          // Restart wins over a beat arriving in the same cycle
          if (load_start) begin
            shadow_q <= '0;
            cnt_q    <= '0;
          end else if (beat) begin
            if (cnt_q == LAST) begin
              par_q    <= sdata;
              sready_q <= 1'b0;
              state_q  <= S_CHECK;
            end else begin
              shadow_q[cnt_q[IW-1:0]] <= sdata;
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_CHECK: begin
          busy_q <= 1'b0;
          if (ok) begin
            key_q   <= shadow_q;
            kv_q    <= 1'b1;
            state_q <= S_LOCKED;
          end else begin
            err_q   <= 1'b1;
            state_q <= S_ERR;
          end
        end
        S_IDLE, S_LOCKED, S_ERR: begin
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sready    = sready_q;
  assign busy      = busy_q;
  assign key_o     = key_q;
  assign key_valid = kv_q;
  assign load_err  = err_q;

endmodule

// File: tb/tb_rll_key_loader.sv
// Bench for rll_key_loader: two instances (reload off/on) share stimulus and
// are checked every cycle against a transaction-level model.
module tb_rll_key_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ls = 1'b0;
  logic sd = 1'b0;
  logic sv = 1'b0;

  logic [1:0]  o_rdy;
  logic [1:0]  o_kv;
  logic [1:0]  o_err;
  logic [1:0]  o_busy;
  logic [15:0] o_key [2];

  int n_cmp = 0;
  int n_bad = 0;
  int beats = 0;

  always #5 clk = ~clk;

  rll_key_loader #(.KEY_W(16), .ALLOW_RELOAD(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .load_start(ls), .sdata(sd),
    .svalid(sv), .sready(o_rdy[0]), .key_o(o_key[0]),
    .key_valid(o_kv[0]), .load_err(o_err[0]), .busy(o_busy[0])
  );

  rll_key_loader #(.KEY_W(16), .ALLOW_RELOAD(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .load_start(ls), .sdata(sd),
    .svalid(sv), .sready(o_rdy[1]), .key_o(o_key[1]),
    .key_valid(o_kv[1]), .load_err(o_err[1]), .busy(o_busy[1])
  );

  // Model: collect 17 bits, verify even parity over all of them, commit
  // one cycle later. Instance 0 treats a locked key as final.
  bit [16:0]   mb    [2];
  int          mn    [2];
  bit          msh   [2];
  bit          mchk  [2];
  bit          mlock [2];
  bit          mkv   [2];
  bit          merr  [2];
  bit          mrdy  [2];
  bit          mbusy [2];
  logic [15:0] mkey  [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mb[i] = '0; mn[i] = 0; msh[i] = 0; mchk[i] = 0;
        mlock[i] = 0; mkv[i] = 0; merr[i] = 0; mrdy[i] = 0;
        mbusy[i] = 0; mkey[i] = '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (mchk[i]) begin
          mchk[i] = 0;
          mbusy[i] = 0;
          if (^mb[i] == 1'b0) begin
            mkey[i] = mb[i][15:0];
            mkv[i] = 1;
            mlock[i] = 1;
          end else begin
            merr[i] = 1;
            mlock[i] = 0;
          end
        end else if (ls && !(mlock[i] && i == 0)) begin
          mb[i] = '0; mn[i] = 0; merr[i] = 0; msh[i] = 1;
          mrdy[i] = 1; mbusy[i] = 1; mlock[i] = 0;
        end else if (msh[i] && sv) begin
          mb[i][mn[i]] = sd;
          mn[i]++;
          if (mn[i] == 17) begin
            msh[i] = 0; mrdy[i] = 0; mchk[i] = 1;
          end
        end
      end
    end
  end

  always @(posedge clk)
    if (sv && o_rdy[1]) beats++;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got %h exp %h", nm, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("key%0d", i), 32'(o_key[i]), 32'(mkey[i]));
      chk($sformatf("kv%0d", i), 32'(o_kv[i]), 32'(mkv[i]));
      chk($sformatf("err%0d", i), 32'(o_err[i]), 32'(merr[i]));
      chk($sformatf("rdy%0d", i), 32'(o_rdy[i]), 32'(mrdy[i]));
      chk($sformatf("busy%0d", i), 32'(o_busy[i]), 32'(mbusy[i]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ls = 0; sv = 0; sd = 0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic start();
    ls = 1'b1;
    step();
    ls = 1'b0;
  endtask

  task automatic beat(input logic b, input int g);
    sv = 1'b1; sd = b;
    step();
    sv = 1'b0;
    repeat (g) step();
  endtask

  task automatic send(input logic [15:0] k, input logic p, input int g);
    for (int i = 0; i < 16; i++) beat(k[i], g);
    beat(p, g);
  endtask

  initial begin
    // 1: clean load
    do_reset();
    chk("rst_key", 32'(o_key[1]), 32'h0);
    chk("rst_rdy", 32'(o_rdy[1]), 32'h0);
    start();
    chk("t1_rdy_first", 32'(o_rdy[1]), 32'h1);
    send(16'hA5C3, 1'b0, 0);
    chk("t1_kv_early", 32'(o_kv[1]), 32'h0);
    step();
    chk("t1_key", 32'(o_key[1]), 32'hA5C3);
    chk("t1_kv", 32'(o_kv[1]), 32'h1);
    chk("t1_busy", 32'(o_busy[1]), 32'h0);
    chk("t1_rdy", 32'(o_rdy[1]), 32'h0);
    chk("t1_model", 32'(mkey[1]), 32'hA5C3);

    // 2: bad parity, then recovery
    do_reset();
    start();
    send(16'hA5C3, 1'b1, 0);
    step();
    chk("t2_err", 32'(o_err[0]), 32'h1);
    chk("t2_kv", 32'(o_kv[0]), 32'h0);
    chk("t2_key", 32'(o_key[0]), 32'h0);
    start();
    chk("t2_err_clr", 32'(o_err[0]), 32'h0);
    send(16'hA5C3, 1'b0, 0);
    step();
    chk("t2_key2", 32'(o_key[0]), 32'hA5C3);
    chk("t2_err2", 32'(o_err[0]), 32'h0);

    // 3: gapped beats
    do_reset();
    start();
    beats = 0;
    send(16'h0001, 1'b1, 2);
    chk("t3_beats", 32'(beats), 32'd17);
    chk("t3_key", 32'(o_key[1]), 32'h0001);
    chk("t3_model", 32'(mkey[1]), 32'h0001);

    // 4: restart colliding with a beat
    do_reset();
    start();
    for (int i = 0; i < 7; i++) beat(1'b0, 0);
    ls = 1; sv = 1; sd = 0;
    step();
    ls = 0; sv = 0;
    send(16'hFFFF, 1'b0, 0);
    step();
    chk("t4_key", 32'(o_key[1]), 32'hFFFF);
    chk("t4_kv", 32'(o_kv[1]), 32'h1);

    // 5: async reset mid-transfer
    do_reset();
    start();
    send(16'h1234, 1'b1, 0);
    step();
    start();
    for (int i = 0; i < 10; i++) beat(1'b1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_key", 32'(o_key[1]), 32'h0);
    chk("t5_kv", 32'(o_kv[1]), 32'h0);
    chk("t5_rdy", 32'(o_rdy[1]), 32'h0);
    chk("t5_busy", 32'(o_busy[1]), 32'h0);
    step();
    rst_n = 1'b1;
    step();
    start();
    send(16'h1234, 1'b1, 0);
    step();
    chk("t5_key2", 32'(o_key[1]), 32'h1234);

    // 6: reload policy
    do_reset();
    start();
    send(16'hA5C3, 1'b0, 0);
    step();
    start();
    chk("t6_rdy0", 32'(o_rdy[0]), 32'h0);
    chk("t6_rdy1", 32'(o_rdy[1]), 32'h1);
    send(16'h00FF, 1'b1, 0);
    step();
    chk("t6_key0", 32'(o_key[0]), 32'hA5C3);
    chk("t6_err0", 32'(o_err[0]), 32'h0);
    chk("t6_key1", 32'(o_key[1]), 32'hA5C3);
    chk("t6_kv1", 32'(o_kv[1]), 32'h1);
    chk("t6_err1", 32'(o_err[1]), 32'h1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
